put_ctrl: RTL and testbench

Transmit-side stream controller for the HPU result path: it buffers result words produced by the core and drives them out on the `put_*` valid/ready stream, framed as one transfer of `len` words ending with `put_last`. It is the outbound counterpart of the inbound `get_*` stream controller. Like that side, it moves data only while `run` is high and `matw` is low. It sits between the core's result writer and the external output stream.

---
 rtl/put_ctrl.sv | 170 +++++++++++++++++
 tb/tb_put_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/put_ctrl.sv
// put_ctrl: transmit-side stream controller for the HPU result path.
// Buffers core result words in a small FIFO and sends them on the put_*
// valid/ready stream as one transfer of len words, with put_last on the final
// word. New output words are loaded only while run_i is high and matw_i is low.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   run_i, matw_i   output-load gating (load only when run_i & ~matw_i)
//   start_i, len_i  begin a transfer of len_i words (len_i sampled on start_i)
//   res_v_i, res_data_i, res_ready_o   core result write handshake
//   put_valid_o, put_data_o, put_last_o, put_ready_i   output stream
//   busy_o          FSM not idle
//   done_o          one-cycle pulse when a transfer ends
//   err_o           sticky; result offered while idle, cleared by start_i
module put_ctrl #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LENW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run_i,
  input  logic            matw_i,
  input  logic            start_i,
  input  logic [LENW-1:0] len_i,
  input  logic            res_v_i,
  input  logic [DW-1:0]   res_data_i,
  output logic            res_ready_o,
  output logic            put_valid_o,
  output logic [DW-1:0]   put_data_o,
  output logic            put_last_o,
  input  logic            put_ready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [LENW-1:0] in_rem_q, in_rem_d;
  logic [LENW-1:0] out_rem_q, out_rem_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            pv_q, pv_d;
  logic [DW-1:0]   pd_q, pd_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic full, empty, push, pop, out_hs;

  // FIFO status: pointers carry one extra wrap bit
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Write side only accepts the words still owed to this transfer
  assign res_ready_o = (state_q == S_SEND) && !full && (in_rem_q != '0);
  assign push        = res_v_i && res_ready_o;

  // Gating applies only to loading; a held word always completes
  assign out_hs = pv_q && put_ready_i;
  assign pop    = (!pv_q || put_ready_i) && !empty && run_i && !matw_i && (state_q == S_SEND);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    in_rem_d  = in_rem_q;
    out_rem_d = out_rem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pv_d      = pv_q;
    pd_d      = pd_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      in_rem_d = in_rem_q - LENW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      pv_d     = 1'b1;
      pd_d     = mem_q[rd_ptr_q[AW-1:0]];
    end else if (out_hs) begin
      pv_d = 1'b0;
    end

    if (out_hs) begin
      out_rem_d = out_rem_q - LENW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (res_v_i) begin
          err_d = 1'b1;
        end
        // start wins over a simultaneous stray result word
        if (start_i) begin
          err_d = 1'b0;
          if (len_i != '0) begin
            in_rem_d  = len_i;
            out_rem_d = len_i;
            state_d   = S_SEND;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (out_hs && (out_rem_q == LENW'(1))) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_rem_q  <= '0;
      out_rem_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pv_q      <= 1'b0;
      pd_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_rem_q  <= in_rem_d;
      out_rem_q <= out_rem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pv_q      <= pv_d;
      pd_q      <= pd_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // FIFO storage; contents are invalidated by the pointer reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= res_data_i;
    end
  end

  assign put_valid_o = pv_q;
  assign put_data_o  = pd_q;
  assign put_last_o  = pv_q && (out_rem_q == LENW'(1));
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_put_ctrl.sv
// Directed self-checking bench for put_ctrl. Inputs change and outputs are
// sampled on the falling clock edge; handshakes are predicted from the values
// visible at that falling edge.
module tb_put_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LENW  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            run, matw, start, res_v, put_ready;
  logic [LENW-1:0] len;
  logic [DW-1:0]   res_data;
  logic            res_ready, put_valid, put_last, busy, done, err;
  logic [DW-1:0]   put_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  put_ctrl #(.DW(DW), .DEPTH(DEPTH), .LENW(LENW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (run),
    .matw_i      (matw),
    .start_i     (start),
    .len_i       (len),
    .res_v_i     (res_v),
    .res_data_i  (res_data),
    .res_ready_o (res_ready),
    .put_valid_o (put_valid),
    .put_data_o  (put_data),
    .put_last_o  (put_last),
    .put_ready_i (put_ready),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  // Pulse start for one cycle; called and returns on a falling edge
  task automatic do_start(input int l);
    start = 1'b1;
    len   = LENW'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (res_ready !== 1'b0) begin n_bad++; $display("FAIL rst_res_ready: got %b want 0", res_ready); end
    n_cmp++; if (put_valid !== 1'b0) begin n_bad++; $display("FAIL rst_put_valid: got %b want 0", put_valid); end
    n_cmp++; if (put_data !== 32'h0) begin n_bad++; $display("FAIL rst_put_data: got %h want 0", put_data); end
    n_cmp++; if (put_last !== 1'b0) begin n_bad++; $display("FAIL rst_put_last: got %b want 0", put_last); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
  endtask

  // len=4 back-to-back with put_ready=1: four consecutive output beats
  task automatic test_back_to_back();
    int acc = 0, got = 0, first = -1, last_hs = -1;
    run = 1'b1; matw = 1'b0; put_ready = 1'b1;
    do_start(4);
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      res_v    = (acc < 4);
      res_data = 32'(32'hA0 + acc);
      if (res_v && res_ready) acc++;
      if (put_valid && put_ready) begin
        n_cmp++; if (put_data !== 32'(32'hA0 + got)) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, put_data, 32'(32'hA0 + got)); end
        n_cmp++; if (put_last !== (got == 3)) begin n_bad++; $display("FAIL b2b_last[%0d]: got %b want %b", got, put_last, (got == 3)); end
        if (first < 0) first = cyc;
        last_hs = cyc;
        got++;
      end
      @(negedge clk);
    end
    res_v = 1'b0;
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL b2b_count: got %0d want 4", got); end
    n_cmp++; if (last_hs - first != 3) begin n_bad++; $display("FAIL b2b_consecutive: got span %0d want 3", last_hs - first); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_done: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_pulse: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  // len=12 with put_ready=0: 8 FIFO words + 1 output word, then drain in order
  task automatic test_backpressure();
    int acc = 0, got = 0;
    run = 1'b1; matw = 1'b0; put_ready = 1'b0;
    do_start(12);
    for (int cyc = 0; cyc < 15; cyc++) begin
      res_v    = (acc < 12);
      res_data = 32'(32'hB0 + acc);
      if (res_v && res_ready) acc++;
      @(negedge clk);
    end
    n_cmp++; if (acc != 9) begin n_bad++; $display("FAIL bp_accepted: got %0d want 9", acc); end
    n_cmp++; if (res_ready !== 1'b0) begin n_bad++; $display("FAIL bp_res_ready: got %b want 0", res_ready); end
    n_cmp++; if (put_data !== 32'hB0) begin n_bad++; $display("FAIL bp_held: got %h want b0", put_data); end
    put_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      res_v    = (acc < 12);
      res_data = 32'(32'hB0 + acc);
      if (res_v && res_ready) acc++;
      if (put_valid && put_ready) begin
        n_cmp++; if (put_data !== 32'(32'hB0 + got)) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", got, put_data, 32'(32'hB0 + got)); end
        n_cmp++; if (put_last !== (got == 11)) begin n_bad++; $display("FAIL bp_last[%0d]: got %b want %b", got, put_last, (got == 11)); end
        got++;
      end
      @(negedge clk);
    end
    res_v = 1'b0;
    n_cmp++; if (got != 12) begin n_bad++; $display("FAIL bp_count: got %0d want 12", got); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  // matw=1 for 5 cycles while put_ready toggles: held word stable, no new loads
  task automatic test_matw_hold();
    int acc = 0, got = 0;
    bit pat [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run = 1'b1; matw = 1'b0; put_ready = 1'b0;
    do_start(8);
    for (int cyc = 0; cyc < 12; cyc++) begin
      res_v    = (acc < 8);
      res_data = 32'(32'hC0 + acc);
      if (res_v && res_ready) acc++;
      @(negedge clk);
    end
    res_v = 1'b0;
    n_cmp++; if (acc != 8) begin n_bad++; $display("FAIL matw_fill: got %0d want 8", acc); end
    matw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put_ready = pat[i];
      n_cmp++; if (put_valid !== (i <= 2)) begin n_bad++; $display("FAIL matw_valid[%0d]: got %b want %b", i, put_valid, (i <= 2)); end
      if (put_valid) begin
        n_cmp++; if (put_data !== 32'(32'hC0 + got)) begin n_bad++; $display("FAIL matw_stable[%0d]: got %h want %h", i, put_data, 32'(32'hC0 + got)); end
        if (put_ready) got++;
      end
      @(negedge clk);
    end
    matw = 1'b0; put_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (put_valid && put_ready) begin
        n_cmp++; if (put_data !== 32'(32'hC0 + got)) begin n_bad++; $display("FAIL matw_data[%0d]: got %h want %h", got, put_data, 32'(32'hC0 + got)); end
        n_cmp++; if (put_last !== (got == 7)) begin n_bad++; $display("FAIL matw_last[%0d]: got %b want %b", got, put_last, (got == 7)); end
        got++;
      end
      @(negedge clk);
    end
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL matw_count: got %0d want 8", got); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL matw_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  // len=3 while the core keeps offering 5 words: only 3 taken
  task automatic test_over_offer();
    int acc = 0, got = 0;
    run = 1'b1; matw = 1'b0; put_ready = 1'b1;
    do_start(3);
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      res_v    = (acc < 5);
      res_data = 32'(32'hD0 + acc);
      if (acc >= 3) begin
        n_cmp++; if (res_ready !== 1'b0) begin n_bad++; $display("FAIL over_res_ready: got %b want 0", res_ready); end
      end
      if (res_v && res_ready) acc++;
      if (put_valid && put_ready) begin
        n_cmp++; if (put_data !== 32'(32'hD0 + got)) begin n_bad++; $display("FAIL over_data[%0d]: got %h want %h", got, put_data, 32'(32'hD0 + got)); end
        n_cmp++; if (put_last !== (got == 2)) begin n_bad++; $display("FAIL over_last[%0d]: got %b want %b", got, put_last, (got == 2)); end
        got++;
      end
      @(negedge clk);
    end
    res_v = 1'b0;
    n_cmp++; if (acc != 3) begin n_bad++; $display("FAIL over_accepted: got %0d want 3", acc); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL over_done: got %b want 1", done); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL over_err: got %b want 0", err); end
  endtask

  // Stray result while idle sets err; zero-length start clears it and pulses done
  task automatic test_zero_len_err();
    res_v = 1'b1; res_data = 32'hEE;
    @(negedge clk);
    res_v = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", err); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
    do_start(0);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zl_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zl_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", err); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zl_done_pulse: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zl_busy_after: got %b want 0", busy); end
  endtask

  // Async reset with FIFO half full, then a clean len=2 transfer
  task automatic test_reset_mid();
    int acc = 0, got = 0;
    run = 1'b1; matw = 1'b0; put_ready = 1'b0;
    do_start(8);
    for (int cyc = 0; cyc < 8; cyc++) begin
      res_v    = (acc < 5);
      res_data = 32'(32'hF0 + acc);
      if (res_v && res_ready) acc++;
      @(negedge clk);
    end
    res_v = 1'b0;
    n_cmp++; if (put_valid !== 1'b1) begin n_bad++; $display("FAIL rm_pre_valid: got %b want 1", put_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (put_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", put_valid); end
    n_cmp++; if (put_data !== 32'h0) begin n_bad++; $display("FAIL rm_data: got %h want 0", put_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (res_ready !== 1'b0) begin n_bad++; $display("FAIL rm_res_ready: got %b want 0", res_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    acc = 0;
    put_ready = 1'b1;
    do_start(2);
    for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
      res_v    = (acc < 2);
      res_data = 32'(32'hE0 + acc);
      if (res_v && res_ready) acc++;
      if (put_valid && put_ready) begin
        n_cmp++; if (put_data !== 32'(32'hE0 + got)) begin n_bad++; $display("FAIL rm_new_data[%0d]: got %h want %h", got, put_data, 32'(32'hE0 + got)); end
        n_cmp++; if (put_last !== (got == 1)) begin n_bad++; $display("FAIL rm_new_last[%0d]: got %b want %b", got, put_last, (got == 1)); end
        got++;
      end
      @(negedge clk);
    end
    res_v = 1'b0;
    n_cmp++; if (got != 2) begin n_bad++; $display("FAIL rm_new_count: got %0d want 2", got); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rm_new_done: got %b want 1", done); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_new_idle: got %b want 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0; matw = 1'b0; start = 1'b0; res_v = 1'b0; put_ready = 1'b0;
    len = '0; res_data = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_matw_hold();
    test_over_offer();
    test_zero_len_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
